// File: rtl/cedula_dispenser_fsm.sv
// Banknote sequencer: splits a withdrawal amount into notes, largest first,
// offers each note to the dispenser over valid/ready and drives the 4-bit
// cedula code shown by the downstream display decoder.
//
// Handshake: a note is transferred on every rising edge where note_valid and
// note_ready are both high; note_valid and cedula_code stay stable while
// note_valid is high and note_ready is low.
module cedula_dispenser_fsm #(
    parameter int W           = 9,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     amount,
    input  logic             note_ready,
    output logic             note_valid,
    output logic [3:0]       cedula_code,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] note_count
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_HOLD,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     note_q, note_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] count_d;
    logic [W-1:0]     sel_note;
    logic [3:0]       sel_code;
    logic [3:0]       code_d;
    logic             valid_d, busy_d, done_d, err_d;

    // A note fits when it does not exceed the remainder and does not leave
    // 1 or 3, which no combination of 2s and 5s can pay out.
    function automatic logic fits(input logic [W-1:0] r, input logic [W-1:0] d);
        logic [W-1:0] left;
        left = r - d;
        return (r >= d) && (left != W'(1)) && (left != W'(3));
    endfunction

    // State and datapath registers, with all outputs registered alongside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            note_q      <= '0;
            hold_q      <= '0;
            note_count  <= '0;
            cedula_code <= 4'h0;
            note_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            note_q      <= note_d;
            hold_q      <= hold_d;
            note_count  <= count_d;
            cedula_code <= code_d;
            note_valid  <= valid_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

    // Next-state and datapath: note selection, handshake and hold timing.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        note_d   = note_q;
        hold_d   = hold_q;
        count_d  = note_count;
        sel_note = W'(2);
        sel_code = 4'h1;

        if (fits(rem_q, W'(100))) begin
            sel_note = W'(100);
            sel_code = 4'h6;
        end else if (fits(rem_q, W'(50))) begin
            sel_note = W'(50);
            sel_code = 4'h5;
        end else if (fits(rem_q, W'(20))) begin
            sel_note = W'(20);
            sel_code = 4'h4;
        end else if (fits(rem_q, W'(10))) begin
            sel_note = W'(10);
            sel_code = 4'h3;
        end else if (fits(rem_q, W'(5))) begin
            sel_note = W'(5);
            sel_code = 4'h2;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    rem_d   = amount;
                    count_d = '0;
                    if (amount == W'(1) || amount == W'(3)) begin
                        state_d = S_ERR;
                    end else if (amount == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                note_d  = sel_note;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (note_valid && note_ready) begin
                    rem_d   = rem_q - note_q;
                    count_d = (note_count == '1) ? note_count : note_count + CNT_W'(1);
                    hold_d  = HW'(HOLD_CYCLES - 1);
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = (rem_q != '0) ? S_SELECT : S_DONE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered; registered above.
    always_comb begin
        code_d  = cedula_code;
        valid_d = (state_d == S_ISSUE);
        busy_d  = (state_d == S_SELECT) || (state_d == S_ISSUE) || (state_d == S_HOLD);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);

        case (state_d)
            S_IDLE:   code_d = 4'h0;
            S_SELECT: begin
                // A fresh request blanks the display; between notes the last
                // code stays up until the next one is chosen.
                if (state_q != S_HOLD) code_d = 4'h0;
            end
            S_ISSUE: begin
                if (state_q == S_SELECT) code_d = sel_code;
            end
            S_HOLD:   code_d = cedula_code;
            S_DONE:   code_d = 4'hE;
            S_ERR:    code_d = 4'hF;
            default:  code_d = 4'h0;
        endcase
    end

endmodule

// File: tb/tb_cedula_dispenser_fsm.sv
// Testbench for cedula_dispenser_fsm: table of requests, hand-written corner
// sequences and random requests, all checked against a note-list model.
module tb_cedula_dispenser_fsm;

    localparam int W     = 9;
    localparam int HOLD  = 4;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     amount = '0;
    logic             note_ready = 1'b0;
    logic             note_valid;
    logic [3:0]       cedula_code;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] note_count;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    bit         m_err;

    int         den_val[6]  = '{100, 50, 20, 10, 5, 2};
    logic [3:0] den_code[6] = '{4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

    typedef struct {
        int amt;
        int stall;
        bit rnd;
        bit exp_err;
        int exp_cnt;
    } vec_t;

    vec_t vecs[12];

    cedula_dispenser_fsm #(.W(W), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .amount(amount),
        .note_ready(note_ready),
        .note_valid(note_valid),
        .cedula_code(cedula_code),
        .busy(busy),
        .done(done),
        .err(err),
        .note_count(note_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_code"}, cedula_code, 4'h0);
        chk({tag, "_valid"}, note_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_count"}, note_count, 0);
    endtask

    // Note list for an amount: repeatedly take the largest note that leaves
    // a payable remainder.
    task automatic model(input int amt);
        int r;
        int pick;
        exp_q.delete();
        m_err = (amt == 1 || amt == 3);
        if (!m_err) begin
            r = amt;
            while (r > 0) begin
                pick = -1;
                for (int i = 0; i < 6; i++) begin
                    if (pick < 0 && den_val[i] <= r && r - den_val[i] != 1 && r - den_val[i] != 3)
                        pick = i;
                end
                if (pick < 0) break;
                exp_q.push_back(den_code[pick]);
                r -= den_val[pick];
            end
        end
    endtask

    task automatic run_request(input int amt, input int stall, input bit rnd);
        int n_acc;
        int hold_left;
        int stall_cnt;
        int cycles;
        int since_acc;
        bit prev_valid;
        logic [3:0] last_code;
        model(amt);
        got_q.delete();
        start = 1'b1;
        amount = W'(amt);
        note_ready = 1'b0;
        cyc();
        start = 1'b0;
        if (m_err) begin
            chk("start_err_flag", err, 1);
        end else if (exp_q.size() == 0) begin
            chk("start_zero_done", done, 1);
        end else begin
            chk("start_busy", busy, 1);
            chk("start_select_novalid", note_valid, 0);
            chk("start_not_done", done, 0);
        end
        n_acc = 0;
        hold_left = 0;
        stall_cnt = 0;
        cycles = 0;
        since_acc = 0;
        prev_valid = 1'b0;
        last_code = 4'h0;
        while (busy === 1'b1 && cycles < 3000) begin
            if (cycles == 1) chk("first_valid_latency", note_valid, 1);
            if (hold_left > 0) begin
                chk("hold_valid_low", note_valid, 0);
                chk("hold_code", cedula_code, last_code);
                hold_left--;
            end
            chk("count_track", note_count, n_acc);
            note_ready = 1'b0;
            if (note_valid) begin
                if (n_acc < exp_q.size()) chk("offer_code", cedula_code, exp_q[n_acc]);
                else chk("extra_note", n_acc, exp_q.size());
                if (!prev_valid && n_acc > 0) chk("note_gap", since_acc, HOLD + 2);
                if (n_acc == 0 && stall_cnt < stall) stall_cnt++;
                else note_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (note_valid && note_ready) begin
                got_q.push_back(cedula_code);
                last_code = cedula_code;
                n_acc++;
                hold_left = HOLD;
                since_acc = 0;
            end
            prev_valid = note_valid;
            cyc();
            cycles++;
            since_acc++;
        end
        note_ready = 1'b0;
        chk("busy_timeout", (cycles < 3000), 1);
        if (m_err) begin
            chk("err_flag", err, 1);
            chk("err_code", cedula_code, 4'hF);
            chk("err_novalid", note_valid, 0);
            chk("err_count", note_count, 0);
            chk("err_no_notes", got_q.size(), 0);
        end else begin
            chk("done_flag", done, 1);
            chk("done_err_low", err, 0);
            chk("done_code", cedula_code, 4'hE);
            chk("done_count", note_count, exp_q.size());
            chk("notes_len", got_q.size(), exp_q.size());
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                chk("note_seq", got_q[i], exp_q[i]);
        end
        cyc();
        chk("final_held_done", done, m_err ? 0 : 1);
        chk("final_held_err", err, m_err ? 1 : 0);
    endtask

    initial begin
        int cycles;

        vecs[0]  = '{186, 0, 1'b0, 1'b0, 7};
        vecs[1]  = '{3,   0, 1'b0, 1'b1, 0};
        vecs[2]  = '{1,   0, 1'b0, 1'b1, 0};
        vecs[3]  = '{0,   0, 1'b0, 1'b0, 0};
        vecs[4]  = '{511, 0, 1'b0, 1'b0, 9};
        vecs[5]  = '{8,   5, 1'b0, 1'b0, 4};
        vecs[6]  = '{2,   0, 1'b1, 1'b0, 1};
        vecs[7]  = '{13,  0, 1'b1, 1'b0, 5};
        vecs[8]  = '{7,   0, 1'b1, 1'b0, 2};
        vecs[9]  = '{9,   2, 1'b1, 1'b0, 3};
        vecs[10] = '{6,   0, 1'b1, 1'b0, 3};
        vecs[11] = '{70,  0, 1'b1, 1'b0, 2};

        // Reset with start asserted: reset wins.
        rst_n = 1'b0;
        start = 1'b1;
        amount = W'(50);
        cyc();
        cyc();
        chk_reset_outputs("reset");
        start = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("idle_stays_idle", busy, 0);
        chk("idle_code", cedula_code, 4'h0);

        // Table of requests.
        for (int v = 0; v < 12; v++) begin
            run_request(vecs[v].amt, vecs[v].stall, vecs[v].rnd);
            chk("tbl_err", err, vecs[v].exp_err);
            chk("tbl_count", note_count, vecs[v].exp_cnt);
        end

        // Reset during the HOLD of the second note of 70.
        start = 1'b1;
        amount = W'(70);
        cyc();
        start = 1'b0;
        note_ready = 1'b1;
        cycles = 0;
        while (note_count !== 2 && cycles < 200) begin
            cyc();
            cycles++;
        end
        chk("midrst_wait", (cycles < 200), 1);
        chk("midrst_in_hold", busy, 1);
        chk("midrst_hold_novalid", note_valid, 0);
        note_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk_reset_outputs("midrst");
        run_request(70, 0, 1'b0);

        // Start pulsed while a note is on offer is ignored.
        start = 1'b1;
        amount = W'(20);
        cyc();
        start = 1'b0;
        cyc();
        chk("busy_start_offer", note_valid, 1);
        chk("busy_start_code", cedula_code, 4'h4);
        start = 1'b1;
        amount = W'(3);
        cyc();
        start = 1'b0;
        chk("busy_start_ignored_err", err, 0);
        chk("busy_start_still_valid", note_valid, 1);
        chk("busy_start_code_kept", cedula_code, 4'h4);
        note_ready = 1'b1;
        cyc();
        note_ready = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cyc();
            cycles++;
        end
        chk("busy_start_wait", (cycles < 200), 1);
        chk("busy_start_done", done, 1);
        chk("busy_start_done_code", cedula_code, 4'hE);
        chk("busy_start_no_err", err, 0);
        chk("busy_start_count", note_count, 1);

        // Random requests with random ready behaviour.
        for (int k = 0; k < 40; k++) begin
            run_request($urandom_range(0, 511), $urandom_range(0, 3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
